// File: rtl/if_stage.sv
// ============================================================================
// if_stage : instruction-fetch stage (PC, IMEM request, IF/ID register)
// Optional: IF_STAGE_PERF_CNT_EN adds FETCH_CNT / WAIT_CNT counters
// Rev 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              PC_STEP      = 4,
    parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_TARGET,
    input  logic            IMEM_BUSYWAIT,
    input  logic [XLEN-1:0] IMEM_INSTR,
    output logic            IMEM_READ,
    output logic [XLEN-1:0] IMEM_ADDR,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] IFID_PC,
    output logic [XLEN-1:0] IFID_INSTR,
    output logic            IFID_VALID
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] FETCH_CNT,
    output logic [XLEN-1:0] WAIT_CNT
`endif
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic            done;
    logic            accept;
    logic [XLEN-1:0] target;

    assign done   = (state_q != BOOT) && !IMEM_BUSYWAIT;
    assign accept = (state_q == FETCH) && done && !STALL && !BRANCH_TAKEN && !FLUSH;
    assign target = BRANCH_TARGET & ~XLEN'(3);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (BRANCH_TAKEN) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    if (IMEM_BUSYWAIT) begin
                        pend_d  = target;
                        state_d = REDIR;
                    end else begin
                        pc_d = target;
                    end
                end else if (FLUSH) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    if (done) pc_d = pc_q + STEP;
                end else if (!STALL) begin
                    if (done) begin
                        ifid_instr_d = IMEM_INSTR;
                        ifid_pc_d    = pc_q;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + STEP;
                    end else begin
                        ifid_valid_d = 1'b0;
                    end
                end
            end
            REDIR: begin
                // The outstanding request to the old PC completes; its data is dropped.
                if (BRANCH_TAKEN || FLUSH) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
                if (BRANCH_TAKEN) begin
                    if (done) begin
                        pc_d    = target;
                        state_d = FETCH;
                    end else begin
                        pend_d = target;
                    end
                end else if (done) begin
                    pc_d    = pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            pend_q       <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign IMEM_READ  = (state_q != BOOT);
    assign IMEM_ADDR  = pc_q;
    assign PC         = pc_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_INSTR = ifid_instr_q;
    assign IFID_VALID = ifid_valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] wait_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (accept && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            if (IMEM_READ && IMEM_BUSYWAIT && (wait_cnt_q != '1))
                wait_cnt_q <= wait_cnt_q + XLEN'(1);
        end
    end

    assign FETCH_CNT = fetch_cnt_q;
    assign WAIT_CNT  = wait_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
`default_nettype none

module tb_if_stage;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        FLUSH;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_INSTR;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] PC;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_INSTR;
    logic        IFID_VALID;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] FETCH_CNT;
    logic [31:0] WAIT_CNT;
`endif

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .FLUSH         (FLUSH),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .IMEM_INSTR    (IMEM_INSTR),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .PC            (PC),
        .IFID_PC       (IFID_PC),
        .IFID_INSTR    (IFID_INSTR),
        .IFID_VALID    (IFID_VALID)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .FETCH_CNT     (FETCH_CNT),
        .WAIT_CNT      (WAIT_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", PC, 32'h0); end
        checks++; if (IFID_PC !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc got %h exp %h", IFID_PC, 32'h0); end
        checks++; if (IFID_INSTR !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp %h", IFID_INSTR, 32'h13); end
        checks++; if (IFID_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", IFID_VALID); end
        checks++; if (IMEM_READ !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", IMEM_READ); end
        RESET = 1'b1;
        tick();
        checks++; if (IMEM_READ !== 1'b1) begin errors++; $display("FAIL boot_read got %b exp 1", IMEM_READ); end
        checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL boot_addr got %h exp %h", IMEM_ADDR, 32'h0); end
    endtask

    task automatic test_first_fetch();
        IMEM_INSTR = 32'h0050_0093;
        IMEM_BUSYWAIT = 1'b0;
        tick();
        checks++; if (IFID_INSTR !== 32'h0050_0093) begin errors++; $display("FAIL ff_instr got %h exp %h", IFID_INSTR, 32'h0050_0093); end
        checks++; if (IFID_PC !== 32'h0) begin errors++; $display("FAIL ff_ifid_pc got %h exp %h", IFID_PC, 32'h0); end
        checks++; if (IFID_VALID !== 1'b1) begin errors++; $display("FAIL ff_valid got %b exp 1", IFID_VALID); end
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL ff_pc got %h exp %h", PC, 32'h4); end
    endtask

    task automatic test_wait_states();
        IMEM_INSTR = 32'h11;
        tick();
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PC !== 32'h8) begin errors++; $display("FAIL ws_pc%0d got %h exp %h", i, PC, 32'h8); end
            checks++; if (IFID_VALID !== 1'b0) begin errors++; $display("FAIL ws_valid%0d got %b exp 0", i, IFID_VALID); end
        end
        IMEM_BUSYWAIT = 1'b0;
        IMEM_INSTR = 32'h22;
        tick();
        checks++; if (IFID_PC !== 32'h8) begin errors++; $display("FAIL ws_ifid_pc got %h exp %h", IFID_PC, 32'h8); end
        checks++; if (IFID_INSTR !== 32'h22) begin errors++; $display("FAIL ws_instr got %h exp %h", IFID_INSTR, 32'h22); end
        checks++; if (PC !== 32'hC) begin errors++; $display("FAIL ws_pc got %h exp %h", PC, 32'hC); end
    endtask

    task automatic test_stall();
        IMEM_INSTR = 32'h33;
        tick();
        STALL = 1'b1;
        IMEM_INSTR = 32'h44;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (PC !== 32'h10) begin errors++; $display("FAIL st_pc%0d got %h exp %h", i, PC, 32'h10); end
            checks++; if (IFID_PC !== 32'hC) begin errors++; $display("FAIL st_ifid_pc%0d got %h exp %h", i, IFID_PC, 32'hC); end
            checks++; if (IFID_INSTR !== 32'h33) begin errors++; $display("FAIL st_instr%0d got %h exp %h", i, IFID_INSTR, 32'h33); end
            checks++; if (IFID_VALID !== 1'b1) begin errors++; $display("FAIL st_valid%0d got %b exp 1", i, IFID_VALID); end
            checks++; if (IMEM_READ !== 1'b1) begin errors++; $display("FAIL st_read%0d got %b exp 1", i, IMEM_READ); end
        end
        STALL = 1'b0;
        tick();
        checks++; if (IFID_PC !== 32'h10) begin errors++; $display("FAIL st_rel_ifid_pc got %h exp %h", IFID_PC, 32'h10); end
        checks++; if (IFID_INSTR !== 32'h44) begin errors++; $display("FAIL st_rel_instr got %h exp %h", IFID_INSTR, 32'h44); end
        checks++; if (PC !== 32'h14) begin errors++; $display("FAIL st_rel_pc got %h exp %h", PC, 32'h14); end
    endtask

    task automatic test_redirect_busy();
        IMEM_BUSYWAIT = 1'b1;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h103;
        tick();
        BRANCH_TAKEN = 1'b0;
        checks++; if (IMEM_ADDR !== 32'h14) begin errors++; $display("FAIL rb_addr0 got %h exp %h", IMEM_ADDR, 32'h14); end
        checks++; if (IFID_VALID !== 1'b0) begin errors++; $display("FAIL rb_valid got %b exp 0", IFID_VALID); end
        checks++; if (IFID_INSTR !== 32'h13) begin errors++; $display("FAIL rb_instr got %h exp %h", IFID_INSTR, 32'h13); end
        tick();
        checks++; if (IMEM_ADDR !== 32'h14) begin errors++; $display("FAIL rb_addr1 got %h exp %h", IMEM_ADDR, 32'h14); end
        checks++; if (IMEM_READ !== 1'b1) begin errors++; $display("FAIL rb_read got %b exp 1", IMEM_READ); end
        IMEM_BUSYWAIT = 1'b0;
        IMEM_INSTR = 32'hDEAD;
        tick();
        checks++; if (PC !== 32'h100) begin errors++; $display("FAIL rb_pc got %h exp %h", PC, 32'h100); end
        checks++; if (IFID_VALID !== 1'b0) begin errors++; $display("FAIL rb_drop_valid got %b exp 0", IFID_VALID); end
        checks++; if (IFID_INSTR !== 32'h13) begin errors++; $display("FAIL rb_drop_instr got %h exp %h", IFID_INSTR, 32'h13); end
        IMEM_INSTR = 32'h55;
        tick();
        checks++; if (IFID_PC !== 32'h100) begin errors++; $display("FAIL rb_ifid_pc got %h exp %h", IFID_PC, 32'h100); end
        checks++; if (IFID_INSTR !== 32'h55) begin errors++; $display("FAIL rb_next_instr got %h exp %h", IFID_INSTR, 32'h55); end
        checks++; if (PC !== 32'h104) begin errors++; $display("FAIL rb_next_pc got %h exp %h", PC, 32'h104); end
    endtask

    task automatic test_redirect_overwrite();
        IMEM_BUSYWAIT = 1'b1;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h300;
        tick();
        BRANCH_TARGET = 32'h401;
        IMEM_BUSYWAIT = 1'b0;
        tick();
        BRANCH_TAKEN = 1'b0;
        checks++; if (PC !== 32'h400) begin errors++; $display("FAIL ro_pc got %h exp %h", PC, 32'h400); end
        checks++; if (IFID_VALID !== 1'b0) begin errors++; $display("FAIL ro_valid got %b exp 0", IFID_VALID); end
        IMEM_INSTR = 32'h66;
        tick();
        checks++; if (IFID_PC !== 32'h400) begin errors++; $display("FAIL ro_ifid_pc got %h exp %h", IFID_PC, 32'h400); end
        checks++; if (PC !== 32'h404) begin errors++; $display("FAIL ro_next_pc got %h exp %h", PC, 32'h404); end
    endtask

    task automatic test_flush_stall();
        FLUSH = 1'b1;
        STALL = 1'b1;
        IMEM_BUSYWAIT = 1'b1;
        tick();
        FLUSH = 1'b0;
        STALL = 1'b0;
        checks++; if (IFID_INSTR !== 32'h13) begin errors++; $display("FAIL fs_instr got %h exp %h", IFID_INSTR, 32'h13); end
        checks++; if (IFID_VALID !== 1'b0) begin errors++; $display("FAIL fs_valid got %b exp 0", IFID_VALID); end
        checks++; if (PC !== 32'h404) begin errors++; $display("FAIL fs_pc got %h exp %h", PC, 32'h404); end
        IMEM_BUSYWAIT = 1'b0;
        IMEM_INSTR = 32'h77;
        tick();
        checks++; if (IFID_PC !== 32'h404) begin errors++; $display("FAIL fs_ifid_pc got %h exp %h", IFID_PC, 32'h404); end
        checks++; if (IFID_VALID !== 1'b1) begin errors++; $display("FAIL fs_next_valid got %b exp 1", IFID_VALID); end
    endtask

    task automatic test_wrap();
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        tick();
        BRANCH_TAKEN = 1'b0;
        checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got %h exp %h", PC, 32'hFFFF_FFFC); end
        IMEM_INSTR = 32'h88;
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wr_wrap_pc got %h exp %h", PC, 32'h0); end
        checks++; if (IFID_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_ifid_pc got %h exp %h", IFID_PC, 32'hFFFF_FFFC); end
    endtask

    task automatic test_reset_mid_redir();
        IMEM_BUSYWAIT = 1'b1;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h500;
        tick();
        BRANCH_TAKEN = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rm_pc got %h exp %h", PC, 32'h0); end
        checks++; if (IMEM_READ !== 1'b0) begin errors++; $display("FAIL rm_read got %b exp 0", IMEM_READ); end
        IMEM_BUSYWAIT = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        IMEM_INSTR = 32'h99;
        tick();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL rm_next_pc got %h exp %h", PC, 32'h4); end
        checks++; if (IFID_PC !== 32'h0) begin errors++; $display("FAIL rm_ifid_pc got %h exp %h", IFID_PC, 32'h0); end
    endtask

`ifdef IF_STAGE_PERF_CNT_EN
    task automatic test_perf();
        RESET = 1'b0;
        tick();
        checks++; if (FETCH_CNT !== 32'h0) begin errors++; $display("FAIL pc_rst_fetch got %0d exp 0", FETCH_CNT); end
        checks++; if (WAIT_CNT !== 32'h0) begin errors++; $display("FAIL pc_rst_wait got %0d exp 0", WAIT_CNT); end
        RESET = 1'b1;
        tick();
        IMEM_BUSYWAIT = 1'b1;
        repeat (3) tick();
        IMEM_BUSYWAIT = 1'b0;
        repeat (5) tick();
        checks++; if (FETCH_CNT !== 32'd5) begin errors++; $display("FAIL pc_fetch got %0d exp 5", FETCH_CNT); end
        checks++; if (WAIT_CNT !== 32'd3) begin errors++; $display("FAIL pc_wait got %0d exp 3", WAIT_CNT); end
        checks++; if (PC !== 32'd20) begin errors++; $display("FAIL pc_pc got %h exp %h", PC, 32'd20); end
    endtask
`endif

    initial begin
        RESET = 1'b0;
        STALL = 1'b0;
        FLUSH = 1'b0;
        BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = 32'h0;
        IMEM_BUSYWAIT = 1'b0;
        IMEM_INSTR = 32'h0;
        repeat (2) tick();
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_stall();
        test_redirect_busy();
        test_redirect_overwrite();
        test_flush_stall();
        test_wrap();
        test_reset_mid_redir();
`ifdef IF_STAGE_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Parametrised instruction-fetch stage that generalises the CPU's bare PC register.
- Owns the PC and drives the instruction-memory request.
- Handles memory wait states, pipeline stall, branch/jump redirect (including redirect while memory is busy) and flush.
- Registers the fetched instruction into the IF/ID pipeline register consumed by reg_file and control_unit in ID.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per accepted fetch
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected on reset/flush/redirect

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous active-low reset
STALL  input  1  hold PC and IF/ID (load-use hazard from ID)
FLUSH  input  1  invalidate IF/ID contents
BRANCH_TAKEN  input  1  redirect request from EX, single-cycle pulse
BRANCH_TARGET  input  XLEN  redirect address
IMEM_BUSYWAIT  input  1  instruction memory not ready
IMEM_INSTR  input  XLEN  instruction data, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_READ  output  1  fetch request
IMEM_ADDR  output  XLEN  fetch address (= PC)
PC  output  XLEN  current fetch PC
IFID_PC  output  XLEN  PC of instruction in IF/ID
IFID_INSTR  output  XLEN  instruction in IF/ID
IFID_VALID  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (RESET=0, asynchronous, dominates everything): PC=RESET_VECTOR, IFID_PC=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0, state BOOT, pending-redirect flag clear.
- States:
  - BOOT: IMEM_READ=0; goes to FETCH on the first edge after reset deassertion.
  - FETCH: IMEM_READ=1, IMEM_ADDR=PC.
  - REDIR: a redirect arrived while memory was busy.
- Fetch completion ("done"): IMEM_BUSYWAIT=0 in FETCH or REDIR.
- Accept: done and STALL=0 in FETCH, with no BRANCH_TAKEN and FLUSH=0 that cycle.
  - IFID_INSTR<=IMEM_INSTR, IFID_PC<=PC, IFID_VALID<=1, PC<=PC+PC_STEP.
  - Latency: request to IF/ID = 1 cycle with zero wait states, 1+N with N busy cycles.
- Not done in FETCH: PC held, IMEM_READ stays 1, IFID_VALID<=0 unless STALL=1 (stall holds IF/ID unchanged).
- STALL=1 without redirect or flush: PC and IF/ID held; IMEM_READ stays 1 (memory must keep data stable for an unchanged address).
- BRANCH_TAKEN=1 (priority over STALL), target taken as BRANCH_TARGET with bits[1:0] cleared:
  - If done that cycle or state is FETCH with busy=0: PC<=target, fetched word discarded, IF/ID<=bubble (NOP_INSTR, VALID=0), stay FETCH.
  - If IMEM_BUSYWAIT=1: latch target in pending register, go REDIR; IF/ID<=bubble.
- REDIR: IMEM_ADDR stays the old PC until busy drops (request is not retracted).
  - On done: returned word discarded, PC<=pending target, go FETCH.
  - A new BRANCH_TAKEN in REDIR overwrites the pending target; if it coincides with done, the new target wins.
- FLUSH=1 (priority over STALL): IF/ID<=bubble; PC advances normally if done, otherwise holds.
- FLUSH and BRANCH_TAKEN in the same cycle: branch rules apply (already bubble).
- Wrap: PC+PC_STEP is modulo 2^XLEN; PC=2^XLEN-4 advances to 0.
- Reset mid-wait or mid-REDIR: pending target dropped, BOOT entered immediately.

Optional Feature:
- Macro IF_STAGE_PERF_CNT_EN defined: adds two output ports.
  - FETCH_CNT (XLEN): counts accepted fetches.
  - WAIT_CNT (XLEN): counts cycles with IMEM_READ=1 and IMEM_BUSYWAIT=1.
  - Both reset to 0, saturate at all-ones.
- Macro undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, BUSYWAIT=0, IMEM_INSTR=0x00500093 -> cycle 1 IMEM_READ=1 ADDR=0; next edge IFID_INSTR=0x00500093, IFID_PC=0, VALID=1, PC=4.
- BUSYWAIT=1 for 3 cycles at PC=8 -> PC held at 8, IFID_VALID=0 for 3 cycles; on release IFID_PC=8, PC=12.
- STALL=1 two cycles at PC=0x10 -> PC and IF/ID unchanged, IMEM_READ=1; after release fetch of 0x10 accepted.
- BRANCH_TAKEN target 0x103 with BUSYWAIT=1 for 2 cycles -> ADDR keeps old PC, IF/ID bubble; after done PC=0x100, old word dropped, next IFID_PC=0x100.
- FLUSH with STALL simultaneously -> IFID_INSTR=0x00000013, VALID=0.
- PC=0xFFFFFFFC accepted -> PC=0. With IF_STAGE_PERF_CNT_EN, 5 accepts plus 3 busy cycles -> FETCH_CNT=5, WAIT_CNT=3.
